// File: rtl/ex5_pkg.sv
// Shared constants for the ex5 memory-mapped LED peripheral.
// Optional broadcast address is enabled by defining EX5_BROADCAST_EN.
package ex5_pkg;

  localparam int unsigned FIELD_W = 2;
  localparam int unsigned FIELD_N = 4;
  localparam int unsigned LED_W   = FIELD_W * FIELD_N;

  // Word addresses (byte address >> 2).
  localparam logic [5:0] LED_F0_ADDR    = 6'h0C;
  localparam logic [5:0] LED_F1_ADDR    = 6'h0D;
  localparam logic [5:0] LED_F2_ADDR    = 6'h0E;
  localparam logic [5:0] LED_F3_ADDR    = 6'h0F;
  localparam logic [5:0] LED_BCAST_ADDR = 6'h10;

  function automatic logic [5:0] field_addr(input int unsigned idx);
    logic [5:0] addr;
    case (idx)
      0:       addr = LED_F0_ADDR;
      1:       addr = LED_F1_ADDR;
      2:       addr = LED_F2_ADDR;
      default: addr = LED_F3_ADDR;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/ex5_addr_dec.sv
// Combinational address decode producing per-field write enables.
// With EX5_BROADCAST_EN defined, LED_BCAST_ADDR enables every field.
module ex5_addr_dec
  import ex5_pkg::*;
(
  input  logic [7:2]         Add,
  input  logic               Write,
  output logic [FIELD_N-1:0] field_we
);

  logic bcast_hit;

`ifdef EX5_BROADCAST_EN
  assign bcast_hit = (Add == LED_BCAST_ADDR);
`else
  assign bcast_hit = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < FIELD_N; gi++) begin : g_dec
      assign field_we[gi] = Write && ((Add == field_addr(gi)) || bcast_hit);
    end
  endgenerate

endmodule

// File: rtl/ex5.sv
// Write-only LED peripheral: four 2-bit fields loaded from SW by address.
// Define EX5_BROADCAST_EN to make word address 0x10 load all fields at once.
module ex5
  import ex5_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:2]       Add,
  input  logic [1:0]       SW,
  input  logic             Write,
  output logic [LED_W-1:0] LED
);

  logic [FIELD_N-1:0] field_we;
  logic [LED_W-1:0]   led_q;
  logic [LED_W-1:0]   led_next;

  ex5_addr_dec u_addr_dec (
    .Add      (Add),
    .Write    (Write),
    .field_we (field_we)
  );

  genvar gi;
  generate
    for (gi = 0; gi < FIELD_N; gi++) begin : g_field
      assign led_next[gi*FIELD_W +: FIELD_W] =
        field_we[gi] ? SW : led_q[gi*FIELD_W +: FIELD_W];
    end
  endgenerate

  // Reset has priority over any write in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_next;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_ex5.sv
// Scoreboard bench for ex5: driver queues hand-computed LED values,
// a negedge monitor pops and compares them against the DUT.
module tb_ex5;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:2] Add;
  logic [1:0] SW;
  logic       Write;
  logic [7:0] LED;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         id_q[$];
  int         vec_id = 0;

`ifdef EX5_BROADCAST_EN
  localparam logic [7:0] BCAST_LED = 8'hAA;
`else
  localparam logic [7:0] BCAST_LED = 8'h44;
`endif

  ex5 dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Add   (Add),
    .SW    (SW),
    .Write (Write),
    .LED   (LED)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, then queue the value LED must show after the edge.
  task automatic step(input logic r, input logic w, input logic [5:0] a,
                      input logic [1:0] s, input logic [7:0] exp);
    @(negedge Clk);
    Reset = r;
    Write = w;
    Add   = a;
    SW    = s;
    @(posedge Clk);
    exp_q.push_back(exp);
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  // Monitor: LED is a registered output, valid every cycle after an edge.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      int         id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      checks++;
      if (LED !== e) begin
        errors++;
        $display("FAIL vec%0d: LED=%02h expected %02h", id, LED, e);
      end else begin
        $display("vec%0d: LED=%02h ok", id, LED);
      end
    end
  end

  initial begin
    Reset = 1'b0;
    Write = 1'b0;
    Add   = '0;
    SW    = '0;

    // Reset wins over a simultaneous write.
    step(1, 1, 6'h0C, 2'b11, 8'h00);
    // Single write to field 0, then hold.
    step(0, 1, 6'h0C, 2'b00, 8'h00);
    step(0, 0, 6'h0C, 2'b00, 8'h00);
    step(0, 1, 6'h0C, 2'b11, 8'h03);
    step(0, 0, 6'h0C, 2'b11, 8'h03);
    // Field isolation.
    step(0, 1, 6'h0C, 2'b00, 8'h00);
    step(0, 1, 6'h0D, 2'b01, 8'h04);
    step(0, 1, 6'h0E, 2'b10, 8'h24);
    step(0, 1, 6'h0F, 2'b11, 8'hE4);
    step(0, 1, 6'h0E, 2'b00, 8'hC4);
    // Write low while Add/SW toggle.
    step(0, 0, 6'h0C, 2'b11, 8'hC4);
    step(0, 0, 6'h0D, 2'b10, 8'hC4);
    step(0, 0, 6'h0E, 2'b01, 8'hC4);
    step(0, 0, 6'h0F, 2'b00, 8'hC4);
    // Unmapped addresses, including neighbours of the map.
    step(0, 1, 6'h00, 2'b11, 8'hC4);
    step(0, 1, 6'h3F, 2'b11, 8'hC4);
    step(0, 1, 6'h0B, 2'b01, 8'hC4);
    // Write held for two edges on field 3.
    step(0, 1, 6'h0F, 2'b01, 8'h44);
    step(0, 1, 6'h0F, 2'b01, 8'h44);
    // Broadcast address (ignored when the feature is disabled).
    step(0, 1, 6'h10, 2'b10, BCAST_LED);
    step(0, 1, 6'h11, 2'b01, BCAST_LED);
    // Reset mid-sequence, then a normal write.
    step(1, 0, 6'h0D, 2'b11, 8'h00);
    step(0, 1, 6'h0E, 2'b11, 8'h30);
    step(0, 0, 6'h0E, 2'b00, 8'h30);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
